// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage MIPS shift execute pipeline (sll/srl/sra) with
// valid/ready handshakes on both sides and a synchronous flush.
// S1 holds the decoded fields and S2 holds the computed result.
// Optional feature: define SHIFT_VAR_EN to add sllv/srlv/srav, which take the
// shift amount from rs_val[4:0]. Without it those functs are reported illegal.
module shift_exec_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rs_val,
    input  logic [31:0] in_rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
`ifdef SHIFT_VAR_EN
    localparam logic [5:0] FN_SLLV    = 6'b000100;
    localparam logic [5:0] FN_SRLV    = 6'b000110;
    localparam logic [5:0] FN_SRAV    = 6'b000111;
`endif

    // S1: decoded fields
    logic        s1_valid_reg;
    logic [31:0] s1_value_reg;
    logic [4:0]  s1_amt_reg;
    logic [5:0]  s1_opcode_reg;
    logic [5:0]  s1_funct_reg;
    logic [4:0]  s1_rd_reg;

    // S2: computed result
    logic        s2_valid_reg;
    logic [31:0] s2_result_reg;
    logic [4:0]  s2_rd_reg;
    logic        s2_illegal_reg;

    logic        s2_advance;
    logic        s1_advance;
    logic [4:0]  in_amt;
    logic [31:0] result_next;
    logic        illegal_next;
    logic        unused_fields;

    // S2 can take new data when it is empty or its result leaves this cycle.
    assign s2_advance = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_advance;
    assign in_ready   = !s1_valid_reg || s1_advance;

    // Variable shifts (funct bit 2 set) take their amount from rs; the amount
    // is resolved at S1 so S2 only ever sees a single 5-bit amount.
`ifdef SHIFT_VAR_EN
    assign in_amt        = in_instr[2] ? in_rs_val[4:0] : in_instr[10:6];
    assign unused_fields = ^{in_instr[25:16], in_rs_val[31:5]};
`else
    assign in_amt        = in_instr[10:6];
    assign unused_fields = ^{in_instr[25:16], in_rs_val};
`endif

    // Shift unit: unsupported opcode/funct yields zero and the illegal flag.
    always_comb begin
        result_next  = 32'd0;
        illegal_next = 1'b1;
        if (s1_opcode_reg == OP_SPECIAL) begin
            case (s1_funct_reg)
                FN_SLL: begin
                    result_next  = s1_value_reg << s1_amt_reg;
                    illegal_next = 1'b0;
                end
                FN_SRL: begin
                    result_next  = s1_value_reg >> s1_amt_reg;
                    illegal_next = 1'b0;
                end
                FN_SRA: begin
                    result_next  = $unsigned($signed(s1_value_reg) >>> s1_amt_reg);
                    illegal_next = 1'b0;
                end
`ifdef SHIFT_VAR_EN
                FN_SLLV: begin
                    result_next  = s1_value_reg << s1_amt_reg;
                    illegal_next = 1'b0;
                end
                FN_SRLV: begin
                    result_next  = s1_value_reg >> s1_amt_reg;
                    illegal_next = 1'b0;
                end
                FN_SRAV: begin
                    result_next  = $unsigned($signed(s1_value_reg) >>> s1_amt_reg);
                    illegal_next = 1'b0;
                end
`endif
                default: begin
                    result_next  = 32'd0;
                    illegal_next = 1'b1;
                end
            endcase
        end
    end

    // S1 register: capture decoded fields on an input transfer; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg  <= 1'b0;
            s1_value_reg  <= 32'd0;
            s1_amt_reg    <= 5'd0;
            s1_opcode_reg <= 6'd0;
            s1_funct_reg  <= 6'd0;
            s1_rd_reg     <= 5'd0;
        end else if (flush) begin
            s1_valid_reg <= 1'b0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_value_reg  <= in_rt_val;
                s1_amt_reg    <= in_amt;
                s1_opcode_reg <= in_instr[31:26];
                s1_funct_reg  <= in_instr[5:0];
                s1_rd_reg     <= in_instr[15:11];
            end
        end
    end

    // S2 register: hold while stalled so outputs stay stable; flush wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_reg   <= 1'b0;
            s2_result_reg  <= 32'd0;
            s2_rd_reg      <= 5'd0;
            s2_illegal_reg <= 1'b0;
        end else if (flush) begin
            s2_valid_reg <= 1'b0;
        end else if (s2_advance) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_result_reg  <= result_next;
                s2_rd_reg      <= s1_rd_reg;
                s2_illegal_reg <= illegal_next;
            end
        end
    end

    assign out_valid   = s2_valid_reg;
    assign out_result  = s2_result_reg;
    assign out_rd      = s2_rd_reg;
    assign out_illegal = s2_illegal_reg;

endmodule
